// File: rtl/program_loader.sv
// program_loader: receives a program as a stream of bytes, assembles them
// big-endian into DATA_SIZE-bit instructions and writes each word into
// program memory at consecutive addresses starting at 0. The CPU core is
// released (cpu_run) only after a complete, successful load.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   start            one-cycle load request (ignored while busy)
//   length           number of instructions to load, sampled on accepted start
//   byte_valid       upstream byte present
//   byte_data        upstream byte
//   byte_ready       loader accepts a byte this cycle (RECEIVE only)
//   mem_write_enable program-memory write strobe (WRITE only)
//   mem_address      program-memory write address
//   mem_data         assembled instruction
//   busy             load in progress (RECEIVE or WRITE)
//   done             last load completed successfully
//   error            last load aborted (length too large or byte timeout)
//   cpu_run          core released from hold (DONE only)
module program_loader #(
  parameter int ADDRESS_SIZE = 8,
  parameter int DATA_SIZE    = 16,
  parameter int SIZE         = 256,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_SIZE:0]   length,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    mem_write_enable,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [DATA_SIZE-1:0]    mem_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cpu_run
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int BW    = $clog2(BYTES) + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  localparam logic [ADDRESS_SIZE:0] SIZE_L     = (ADDRESS_SIZE + 1)'(SIZE);
  localparam logic [BW-1:0]         BYTE_LAST  = BW'(BYTES - 1);
  localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t state, state_next;

  logic [ADDRESS_SIZE-1:0] address;
  logic [ADDRESS_SIZE:0]   instr_count;
  logic [ADDRESS_SIZE:0]   length_q;
  logic [BW-1:0]           byte_count;
  logic [TW-1:0]           timeout_count;
  logic [DATA_SIZE-1:0]    shift;
  logic [DATA_SIZE-1:0]    next_word;

  logic accept;
  logic word_complete;
  logic timed_out;

  assign accept        = (state == RECEIVE) && byte_valid;
  assign word_complete = accept && (byte_count == BYTE_LAST);
  assign timed_out     = (state == RECEIVE) && !byte_valid &&
                         (timeout_count == TIMEOUT_LAST);
  assign next_word     = (shift << 8) | DATA_SIZE'(byte_data);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (length > SIZE_L)     state_next = ERROR;
          else if (length == '0)   state_next = DONE;
          else                     state_next = RECEIVE;
        end
      end
      RECEIVE: begin
        if (word_complete)  state_next = WRITE;
        else if (timed_out) state_next = ERROR;
      end
      WRITE: begin
        if (instr_count + 1'b1 == length_q) state_next = DONE;
        else                                state_next = RECEIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mem_address/mem_data are captured on the edge that enters WRITE so that
  // they hold steady outside WRITE while the internal address advances.
  always_ff @(posedge clock) begin
    if (!reset) begin
      address       <= '0;
      instr_count   <= '0;
      length_q      <= '0;
      byte_count    <= '0;
      timeout_count <= '0;
      shift         <= '0;
      mem_address   <= '0;
      mem_data      <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (state_next == RECEIVE) begin
            address       <= '0;
            instr_count   <= '0;
            length_q      <= length;
            byte_count    <= '0;
            timeout_count <= '0;
            shift         <= '0;
          end
        end
        RECEIVE: begin
          if (accept) begin
            shift         <= next_word;
            timeout_count <= '0;
            if (byte_count == BYTE_LAST) begin
              byte_count  <= '0;
              mem_data    <= next_word;
              mem_address <= address;
            end else begin
              byte_count <= byte_count + 1'b1;
            end
          end else begin
            timeout_count <= timeout_count + 1'b1;
          end
        end
        WRITE: begin
          address       <= address + 1'b1;
          instr_count   <= instr_count + 1'b1;
          timeout_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign byte_ready       = (state == RECEIVE);
  assign mem_write_enable = (state == WRITE);
  assign busy             = (state == RECEIVE) || (state == WRITE);
  assign done             = (state == DONE);
  assign error            = (state == ERROR);
  assign cpu_run          = (state == DONE);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads against program_loader.
// Expected memory writes are derived from the byte stream of each load and
// queued; a monitor pops and compares on every observed write strobe.
module tb_program_loader;

  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int SZ      = 256;
  localparam int TMO     = 1024;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   length;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          busy, done, error, cpu_run;

  program_loader #(
    .ADDRESS_SIZE(AW),
    .DATA_SIZE   (DW),
    .SIZE        (SZ),
    .TIMEOUT     (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .length          (length),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .cpu_run         (cpu_run)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];   // {address, data}
  logic [7:0]  bytes_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset) begin
      chk("status_exclusive", int'(busy) + int'(done) + int'(error) <= 1, 1);
      if (mem_write_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(mem_address), -1);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          chk("write_addr", int'(mem_address), int'(e[23:16]));
          chk("write_data", int'(mem_data), int'(e[15:0]));
        end
      end
    end
  end

  // Reference: instruction i is bytes 2i (high) and 2i+1 (low), at address i.
  task automatic model_load(input int nwords);
    for (int i = 0; i < nwords; i++)
      exp_q.push_back({i[7:0], bytes_q[2*i], bytes_q[2*i+1]});
  endtask

  task automatic fill_random(input int nbytes);
    bytes_q.delete();
    for (int i = 0; i < nbytes; i++) bytes_q.push_back(8'($urandom));
  endtask

  task automatic step;
    @(negedge clock); #1;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = (AW + 1)'(len);
    @(posedge clock); #1;
    start  = 1'b0;
    step();
  endtask

  // mode 0: byte_valid held high, 1: toggling, 2: random gaps 0..3
  task automatic stream(input int nbytes, input int mode, input bit poke);
    for (int k = 0; k < nbytes; k++) begin
      int guard;
      int gap;
      guard = 0;
      while (!byte_ready && guard < 100) begin
        step();
        guard++;
      end
      if (!byte_ready) begin
        chk("byte_ready_timeout", 0, 1);
        return;
      end
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
      if (gap > 0) begin
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if (poke && k == 1 && g == 0) begin
            start  = 1'b1;
            length = '0;
          end
          step();
          start = 1'b0;
        end
      end
      byte_valid = 1'b1;
      byte_data  = bytes_q[k];
      @(posedge clock); #1;
      step();
    end
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_busy_in_write"}, int'(busy), 1);
    byte_valid = 1'b0;
    step();
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_cpu_run"}, int'(cpu_run), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_writes_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_outputs"},
        int'({byte_ready, mem_write_enable, busy, done, error, cpu_run}), 0);
    chk({tag, "_mem_address"}, int'(mem_address), 0);
    chk({tag, "_mem_data"}, int'(mem_data), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; length = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b1;
    step();
    check_reset_values("idle");

    // Directed back-to-back load
    bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    model_load(2);
    do_start(2);
    chk("l2_busy", int'(busy), 1);
    stream(4, 0, 1'b0);
    expect_done("l2");

    // Zero-length load
    do_start(0);
    chk("l0_done", int'(done), 1);
    chk("l0_cpu_run", int'(cpu_run), 1);
    chk("l0_write", int'(mem_write_enable), 0);

    // Oversized load
    do_start(SZ + 1);
    chk("l257_error", int'(error), 1);
    chk("l257_cpu_run", int'(cpu_run), 0);
    for (int i = 0; i < 4; i++) begin
      chk("l257_byte_ready", int'(byte_ready), 0);
      step();
    end

    // Byte timeout after a partial word
    bytes_q = '{8'hAB};
    do_start(1);
    stream(1, 0, 1'b0);
    byte_valid = 1'b0;
    repeat (TMO - 1) step();
    chk("tmo_still_busy", int'(busy), 1);
    chk("tmo_not_error", int'(error), 0);
    step();
    chk("tmo_error", int'(error), 1);
    chk("tmo_cpu_run", int'(cpu_run), 0);
    chk("tmo_busy", int'(busy), 0);

    // Reset mid-load after the first write
    fill_random(6);
    model_load(1);
    do_start(3);
    stream(2, 0, 1'b0);
    byte_valid = 1'b0;
    step();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    step();
    check_reset_values("midreset");
    chk("midreset_pending", exp_q.size(), 0);
    bytes_q = '{8'hCA, 8'hFE};
    model_load(1);
    do_start(1);
    stream(2, 2, 1'b0);
    expect_done("cafe");

    // Toggling byte_valid with a start pulse while busy
    bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    model_load(2);
    do_start(2);
    stream(4, 1, 1'b1);
    expect_done("toggle");

    // Full-size load
    fill_random(2 * SZ);
    model_load(SZ);
    do_start(SZ);
    stream(2 * SZ, 0, 1'b0);
    expect_done("full");

    // Randomized loads
    for (int t = 0; t < 20; t++) begin
      int len;
      len = int'($urandom_range(1, 6));
      fill_random(2 * len);
      model_load(len);
      do_start(len);
      stream(2 * len, 2, 1'b0);
      expect_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
